// File: rtl/bcd_count_mux.sv
// bcd_count_mux: N-digit BCD up/down counter with programmable prescaler and multiplexed digit scanner
module bcd_count_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_WIDTH  = 24,
  parameter int MAX_COUNT  = 10_000_000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [CNT_WIDTH-1:0]    compare_in,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    carry,
  output logic [CNT_WIDTH-1:0]    prescale,
  output logic [NUM_DIGITS-1:0]   scan_sel,
  output logic [3:0]              scan_digit
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CNT_WIDTH-1:0] compare;
  logic [DW-1:0]        step_val, load_val;
  logic                 wrap, scan_end;
  logic [15:0]          scan_cnt;
  logic [IW-1:0]        idx, idx_n;
  assign compare  = compare_in == '0 ? CNT_WIDTH'(MAX_COUNT) : compare_in;
  assign scan_end = scan_cnt == 16'(SCAN_DIV - 1);
  assign idx_n    = scan_end ? (idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1)) : idx;
  // Ripple +1/-1 through the digits; wrap survives only if every digit rolls over. Load nibbles clamp to 9.
  always_comb begin
    step_val = digits;
    load_val = load_value;
    wrap     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step_val[4*i +: 4] = !wrap ? digits[4*i +: 4] :
                           up_down ? (digits[4*i +: 4] == 4'd9 ? 4'd0 : digits[4*i +: 4] + 4'd1) :
                                     (digits[4*i +: 4] == 4'd0 ? 4'd9 : digits[4*i +: 4] - 4'd1);
      wrap = wrap && digits[4*i +: 4] == (up_down ? 4'd9 : 4'd0);
      load_val[4*i +: 4] = load_value[4*i +: 4] > 4'd9 ? 4'd9 : load_value[4*i +: 4];
    end
  end
  // Prescaler and counter: load beats step, step fires when prescale has reached compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits   <= '0;
      prescale <= '0;
      tick     <= 1'b0;
      carry    <= 1'b0;
    end else if (load) begin
      digits   <= load_val;
      prescale <= '0;
      tick     <= 1'b0;
      carry    <= 1'b0;
    end else if (enable && prescale >= compare) begin
      digits   <= step_val;
      prescale <= '0;
      tick     <= 1'b1;
      carry    <= wrap;
    end else begin
      prescale <= enable ? prescale + CNT_WIDTH'(1) : prescale;
      tick     <= 1'b0;
      carry    <= 1'b0;
    end
  end
  // Free-running scanner; outputs follow the next index so select and digit stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt   <= '0;
      idx        <= '0;
      scan_sel   <= NUM_DIGITS'(1);
      scan_digit <= '0;
    end else begin
      scan_cnt   <= scan_end ? '0 : scan_cnt + 16'd1;
      idx        <= idx_n;
      scan_sel   <= NUM_DIGITS'(1) << idx_n;
      scan_digit <= digits[{idx_n, 2'b00} +: 4];
    end
  end
endmodule

// File: tb/tb_bcd_count_mux.sv
// tb_bcd_count_mux: scoreboard bench for the BCD counter and scanner
module tb_bcd_count_mux;
  logic        clk = 0, reset = 1, enable = 0, up_down = 1, load = 0;
  logic [15:0] load_value = '0;
  logic [7:0]  compare_in = '0;
  logic [15:0] digits;
  logic        tick, carry;
  logic [7:0]  prescale;
  logic [3:0]  scan_sel, scan_digit;
  int checks = 0, failures = 0;
  typedef struct packed {logic [15:0] d; logic c;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_count_mux #(.NUM_DIGITS(4), .CNT_WIDTH(8), .MAX_COUNT(3), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .compare_in(compare_in), .digits(digits), .tick(tick),
    .carry(carry), .prescale(prescale), .scan_sel(scan_sel), .scan_digit(scan_digit));

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int to_int(logic [15:0] v);
    return int'(v[3:0]) + 10 * int'(v[7:4]) + 100 * int'(v[11:8]) + 1000 * int'(v[15:12]);
  endfunction

  function automatic logic [15:0] to_bcd(int x);
    return {4'(x / 1000 % 10), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
  endfunction

  function automatic exp_t model(logic [15:0] v, logic up);
    exp_t e;
    int x;
    x = to_int(v);
    e.c = up ? x == 9999 : x == 0;
    x = up ? (x + 1) % 10000 : (x + 9999) % 10000;
    e.d = to_bcd(x);
    return e;
  endfunction

  task automatic do_reset;
    reset = 1; load = 0; enable = 0; compare_in = '0;
    cyc(2);
    reset = 0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 40);
    if (!tick) n = -1;
  endtask

  task automatic pulse_load(logic [15:0] v);
    load = 1; load_value = v;
    cyc();
    load = 0;
  endtask

  task automatic test_reset;
    reset = 1; enable = 1; load = 1; load_value = 16'h1234;
    cyc(2);
    checks++; if (digits !== 16'h0) begin failures++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++; if (prescale !== 8'h0) begin failures++; $display("FAIL reset_prescale got=%h exp=00", prescale); end
    checks++; if (tick !== 1'b0 || carry !== 1'b0) begin failures++; $display("FAIL reset_pulses tick=%b carry=%b exp=0,0", tick, carry); end
    checks++; if (scan_sel !== 4'b0001 || scan_digit !== 4'h0) begin failures++; $display("FAIL reset_scan sel=%b dig=%h exp=0001,0", scan_sel, scan_digit); end
    reset = 0; load = 0; enable = 0;
  endtask

  task automatic test_up_count;
    logic [15:0] v;
    exp_t e;
    int n;
    do_reset();
    up_down = 1; enable = 1;
    v = '0;
    for (int i = 0; i < 12; i++) begin e = model(v, 1'b1); sb.push_back(e); v = e.d; end
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      checks++; if (n !== 4) begin failures++; $display("FAIL up_period got=%0d exp=4", n); end
      checks++; if (digits !== e.d || carry !== e.c) begin failures++; $display("FAIL up_step got=%h/%b exp=%h/%b", digits, carry, e.d, e.c); end
    end
    cyc();
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL up_tick_width got=%b exp=0", tick); end
    pulse_load(16'h9998);
    v = 16'h9998;
    for (int i = 0; i < 2; i++) begin e = model(v, 1'b1); sb.push_back(e); v = e.d; end
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      checks++; if (n !== 4 || digits !== e.d || carry !== e.c) begin failures++; $display("FAIL up_wrap got=%0d/%h/%b exp=4/%h/%b", n, digits, carry, e.d, e.c); end
    end
    cyc();
    checks++; if (carry !== 1'b0 || tick !== 1'b0) begin failures++; $display("FAIL up_carry_width got=%b/%b exp=0/0", carry, tick); end
  endtask

  task automatic test_down;
    logic [15:0] v;
    exp_t e;
    int n;
    do_reset();
    up_down = 0; enable = 1;
    v = '0;
    for (int i = 0; i < 2; i++) begin e = model(v, 1'b0); sb.push_back(e); v = e.d; end
    while (sb.size() > 0) begin
      wait_tick(n);
      e = sb.pop_front();
      checks++; if (n !== 4 || digits !== e.d || carry !== e.c) begin failures++; $display("FAIL down_step got=%0d/%h/%b exp=4/%h/%b", n, digits, carry, e.d, e.c); end
    end
    pulse_load(16'h0010);
    sb.push_back(model(16'h0010, 1'b0));
    sb.push_back(model(16'h0009, 1'b0));
    wait_tick(n);
    e = sb.pop_front();
    checks++; if (digits !== e.d || carry !== e.c) begin failures++; $display("FAIL down_borrow got=%h/%b exp=%h/%b", digits, carry, e.d, e.c); end
    cyc();
    up_down = 1;
    cyc();
    up_down = 0;
    wait_tick(n);
    e = sb.pop_front();
    checks++; if (digits !== e.d) begin failures++; $display("FAIL down_updown_sample got=%h exp=%h", digits, e.d); end
  endtask

  task automatic test_load;
    do_reset();
    up_down = 1; enable = 1;
    cyc(2);
    checks++; if (prescale !== 8'd2) begin failures++; $display("FAIL load_pre got=%0d exp=2", prescale); end
    pulse_load(16'h004F);
    checks++; if (digits !== 16'h0049 || prescale !== 8'd0 || tick !== 1'b0) begin failures++; $display("FAIL load_clamp got=%h/%0d/%b exp=0049/0/0", digits, prescale, tick); end
    cyc(3);
    load = 1; load_value = 16'h1234;
    cyc();
    load = 0;
    checks++; if (digits !== 16'h1234 || tick !== 1'b0 || carry !== 1'b0 || prescale !== 8'd0) begin failures++; $display("FAIL load_vs_step got=%h/%b/%b/%0d exp=1234/0/0/0", digits, tick, carry, prescale); end
    pulse_load(16'hFAB9);
    checks++; if (digits !== 16'h9999) begin failures++; $display("FAIL load_clamp_all got=%h exp=9999", digits); end
    enable = 0;
    pulse_load(16'h0042);
    checks++; if (digits !== 16'h0042) begin failures++; $display("FAIL load_paused got=%h exp=0042", digits); end
  endtask

  task automatic test_compare;
    int n;
    do_reset();
    compare_in = 8'd10; enable = 1;
    cyc(8);
    checks++; if (prescale !== 8'd8) begin failures++; $display("FAIL cmp_pre got=%0d exp=8", prescale); end
    compare_in = 8'd5;
    cyc();
    checks++; if (tick !== 1'b1 || prescale !== 8'd0) begin failures++; $display("FAIL cmp_lower got=%b/%0d exp=1/0", tick, prescale); end
    wait_tick(n);
    checks++; if (n !== 6) begin failures++; $display("FAIL cmp_period5 got=%0d exp=6", n); end
    compare_in = 8'd0;
    wait_tick(n);
    checks++; if (n !== 4) begin failures++; $display("FAIL cmp_default got=%0d exp=4", n); end
  endtask

  task automatic test_pause;
    logic [15:0] d0;
    logic [3:0]  p;
    int changes;
    do_reset();
    up_down = 1; enable = 1;
    cyc(2);
    d0 = digits; enable = 0; changes = 0; p = scan_sel;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++; if (prescale !== 8'd2 || digits !== d0 || tick !== 1'b0) begin failures++; $display("FAIL pause_hold got=%0d/%h/%b exp=2/%h/0", prescale, digits, tick, d0); end
      if (scan_sel !== p) changes++;
      p = scan_sel;
    end
    checks++; if (changes !== 5) begin failures++; $display("FAIL pause_scan got=%0d exp=5", changes); end
    enable = 1;
    cyc();
    checks++; if (prescale !== 8'd3) begin failures++; $display("FAIL pause_resume got=%0d exp=3", prescale); end
    cyc();
    checks++; if (tick !== 1'b1 || digits !== 16'h0001) begin failures++; $display("FAIL pause_step got=%b/%h exp=1/0001", tick, digits); end
  endtask

  task automatic test_scan;
    logic [3:0] p, es, ed;
    int n;
    do_reset();
    pulse_load(16'h1234);
    n = 0; p = scan_sel;
    cyc();
    while (!(scan_sel == 4'b0001 && p != 4'b0001) && n < 40) begin p = scan_sel; cyc(); n++; end
    checks++; if (n >= 40) begin failures++; $display("FAIL scan_align got=timeout exp=0001 slot"); end
    for (int i = 0; i < 16; i++) begin
      es = 4'(1 << (i / 4));
      ed = 4'(4 - i / 4);
      checks++; if (scan_sel !== es || scan_digit !== ed) begin failures++; $display("FAIL scan_seq i=%0d got=%b/%h exp=%b/%h", i, scan_sel, scan_digit, es, ed); end
      cyc();
    end
    cyc(2);
    reset = 1;
    cyc();
    reset = 0;
    checks++; if (scan_sel !== 4'b0001 || digits !== 16'h0 || scan_digit !== 4'h0 || tick !== 1'b0) begin failures++; $display("FAIL scan_reset got=%b/%h/%h/%b exp=0001/0000/0/0", scan_sel, digits, scan_digit, tick); end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down();
    test_load();
    test_compare();
    test_pause();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_count_mux.md
Name: bcd_count_mux

Overview:
- Parametrised successor to the single-digit seconds counter.
- N-digit BCD up/down counter advanced by a programmable prescaler, with synchronous load, pause and wrap/borrow flagging.
- Includes a time-multiplexed digit scanner, so one 7-segment decoder can drive N common-cathode digits.
- Sits between the top-level pin wrapper and the seg7 decoder.

Parameters:
- NUM_DIGITS, 4: number of BCD digits (1..8).
- CNT_WIDTH, 24: prescaler width.
- MAX_COUNT, 10_000_000: default prescaler terminal value, used when compare_in == 0.
- SCAN_DIV, 1000: clocks per scan slot (16-bit range).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = prescaler runs; 0 = pause.
- up_down  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_value  in  4*NUM_DIGITS  BCD load data; digit0 is in bits [3:0].
- compare_in  in  CNT_WIDTH  prescaler terminal value; 0 selects MAX_COUNT.
- digits  out  4*NUM_DIGITS  current BCD value; digit0 is the LSD.
- tick  out  1  one-cycle pulse on each count step.
- carry  out  1  one-cycle pulse on wrap (up) or borrow-wrap (down).
- prescale  out  CNT_WIDTH  current prescaler value, for debug/gpio.
- scan_sel  out  NUM_DIGITS  one-hot active-digit select.
- scan_digit  out  4  BCD of the selected digit.

Behaviour:
- All outputs are registered.
- Reset values:
  - digits = 0, prescale = 0, tick = 0, carry = 0.
  - scan index = 0, so scan_sel = 1 and scan_digit = 0.
  - scan counter = 0.
- compare = (compare_in == 0) ? MAX_COUNT : compare_in; evaluated every cycle.
- Prescaler, enable = 1:
  - If prescale >= compare: prescale <= 0 and a step occurs.
  - Otherwise: prescale <= prescale + 1.
  - The >= comparison is required, so lowering compare mid-count wraps on the next clock instead of rolling through 2^CNT_WIDTH.
- Step period is compare + 1 clocks.
- Pause (enable = 0): prescale, digits and the step logic hold; tick = 0 and carry = 0.
- Step behaviour: digits are updated and tick = 1 in the clock edge after the cycle where prescale >= compare was seen; latency is 1.
- Up counting:
  - digit0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - All digits 9 → all digits 0, with carry = 1 in the same cycle as tick.
- Down counting:
  - digit0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - All digits 0 → all digits 9, with carry = 1.
- up_down is sampled at the step cycle only; changing it between steps has no other effect.
- Load has priority over a step and over enable:
  - digits <= load_value, with any nibble > 9 clamped to 9.
  - prescale <= 0, tick = 0, carry = 0.
- Load while reset is asserted: reset wins.
- Scanner:
  - Free-running and independent of enable and load.
  - The scan counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 it clears and the scan index advances, wrapping from NUM_DIGITS-1 to 0.
  - scan_sel = 1 << index.
  - scan_digit is the digit at the current index, taken from the registered digits value, so it reflects an update one clock later.
- Reset mid-operation (any cycle): all state returns to reset values on the next edge; no tick or carry is emitted.
- No internal clock enables or derived clocks; all logic is on clk.

Test Plan:
- NUM_DIGITS=2, MAX_COUNT=3, compare_in=0, up, enable=1 from reset → tick every 4 clocks; digits 00,01,…,09,10 (digit1 increments); after 100 steps digits = 00 with carry = 1 for exactly one cycle alongside tick.
- Down count from reset, NUM_DIGITS=2 → first step gives digits = 99 and carry = 1; next step gives 98 and carry = 0; 10 → 09 borrows correctly.
- load=1 with load_value=0x4F while prescale = 2 → next cycle digits = 0x49 (F clamped to 9), prescale = 0, tick = 0; load asserted together with a would-be step → no tick, load value wins.
- compare_in=10, prescale reaches 8, compare_in changes to 5 → next edge prescale = 0 and tick fires; subsequent period is 6 clocks; compare_in back to 0 → period MAX_COUNT+1.
- enable=0 for 20 clocks mid-period → prescale and digits frozen, no tick; on re-enable the count resumes from the held prescale value; scan_sel keeps rotating throughout.
- SCAN_DIV=4, NUM_DIGITS=4, digits loaded to 0x1234 → scan_sel sequence 0001, 0010, 0100, 1000 with scan_digit 4, 3, 2, 1, each held for 4 clocks; assert reset mid-scan → scan_sel = 0001 and digits = 0 on the next edge.
